// File: rtl/mips_tb_pkg.sv
// Shared types and default signature constants for the MIPS program loader/monitor.
package mips_tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RST_CORE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISMATCH = 2'd1,
        FC_TIMEOUT  = 2'd2
    } fail_code_e;

    localparam int DEF_PASS_ADDR = 84;
    localparam int DEF_PASS_DATA = 7;

endpackage

// File: rtl/mips_run_watchdog.sv
// RUN-phase cycle counter and pass-signature comparator; emits hit_pass/hit_fail/timeout strobes.
module mips_run_watchdog #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT   = 1024,
    parameter int PASS_ADDR = 84,
    parameter int PASS_DATA = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         run,
    input  logic                         memWrite,
    input  logic [ADDR_W-1:0]            Address,
    input  logic [DATA_W-1:0]            writeData,
    output logic [$clog2(TIMEOUT+1)-1:0] cycle_count,
    output logic                         hit_pass,
    output logic                         hit_fail,
    output logic                         timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic sig_hit;

    assign sig_hit  = run && memWrite && (Address == ADDR_W'(PASS_ADDR));
    assign hit_pass = sig_hit && (writeData == DATA_W'(PASS_DATA));
    assign hit_fail = sig_hit && (writeData != DATA_W'(PASS_DATA));
    // A signature hit in the last allowed cycle takes priority over the timeout.
    assign timeout  = run && !sig_hit && (cycle_count == CNT_W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cycle_count <= '0;
        end else if (run && !sig_hit && !timeout) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mips_prog_loader_monitor.sv
// Streams a program into instruction memory, pulses core reset, then watches for the pass signature.
module mips_prog_loader_monitor
    import mips_tb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int ADDR_STEP  = 4,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 64,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1024,
    parameter int PASS_ADDR  = DEF_PASS_ADDR,
    parameter int PASS_DATA  = DEF_PASS_DATA
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           prog_valid,
    input  logic [DATA_W-1:0]              prog_data,
    input  logic                           prog_last,
    output logic                           prog_ready,
    output logic                           instwen,
    output logic [ADDR_W-1:0]              addwrite,
    output logic [DATA_W-1:0]              instrdatain,
    output logic                           core_reset,
    input  logic                           memWrite,
    input  logic [ADDR_W-1:0]              Address,
    input  logic [DATA_W-1:0]              writeData,
    output logic                           done,
    output logic                           pass,
    output logic [1:0]                     fail_code,
    output logic                           ovf,
    output logic [$clog2(MAX_WORDS+1)-1:0] word_count,
    output logic [$clog2(TIMEOUT+1)-1:0]   cycle_count
);

    localparam int WC_W = $clog2(MAX_WORDS + 1);
    localparam int RC_W = $clog2(RST_CYCLES + 1);

    state_e            state, state_next;
    fail_code_e        fc_q;
    logic [RC_W-1:0]   rst_cnt;
    logic              load_start;
    logic              run;
    logic              handshake;
    logic              at_capacity;
    logic              hit_pass, hit_fail, timeout;
    logic [ADDR_W-1:0] next_addr;

    assign run         = (state == ST_RUN);
    assign handshake   = prog_valid && prog_ready;
    assign at_capacity = (word_count == WC_W'(MAX_WORDS - 1));
    assign next_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(word_count) * ADDR_W'(ADDR_STEP);
    assign fail_code   = fc_q;

    mips_run_watchdog #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .TIMEOUT   (TIMEOUT),
        .PASS_ADDR (PASS_ADDR),
        .PASS_DATA (PASS_DATA)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .clear       (load_start),
        .run         (run),
        .memWrite    (memWrite),
        .Address     (Address),
        .writeData   (writeData),
        .cycle_count (cycle_count),
        .hit_pass    (hit_pass),
        .hit_fail    (hit_fail),
        .timeout     (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        prog_ready = 1'b0;
        core_reset = 1'b1;
        done       = 1'b0;
        pass       = 1'b0;
        load_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    load_start = 1'b1;
                end
            end
            ST_LOAD: begin
                prog_ready = 1'b1;
                if (prog_valid && (prog_last || at_capacity)) state_next = ST_RST_CORE;
            end
            ST_RST_CORE: begin
                if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_next = ST_RUN;
            end
            ST_RUN: begin
                core_reset = 1'b0;
                if (hit_pass)                 state_next = ST_PASS;
                else if (hit_fail || timeout) state_next = ST_FAIL;
            end
            ST_PASS, ST_FAIL: begin
                done = 1'b1;
                pass = (state == ST_PASS);
                if (start) begin
                    state_next = ST_LOAD;
                    load_start = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Write port is registered: a handshake shows up on instwen exactly one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            instwen     <= 1'b0;
            addwrite    <= '0;
            instrdatain <= '0;
            word_count  <= '0;
            ovf         <= 1'b0;
            fc_q        <= FC_NONE;
            rst_cnt     <= '0;
        end else begin
            instwen <= 1'b0;
            rst_cnt <= (state == ST_RST_CORE) ? rst_cnt + RC_W'(1) : '0;
            if (load_start) begin
                word_count <= '0;
                ovf        <= 1'b0;
                fc_q       <= FC_NONE;
            end
            if (handshake) begin
                instwen     <= 1'b1;
                addwrite    <= next_addr;
                instrdatain <= prog_data;
                word_count  <= word_count + WC_W'(1);
                if (!prog_last && at_capacity) ovf <= 1'b1;
            end
            if (run) begin
                if (hit_fail)     fc_q <= FC_MISMATCH;
                else if (timeout) fc_q <= FC_TIMEOUT;
            end
        end
    end

endmodule

// File: doc/mips_prog_loader_monitor.md
Name: mips_prog_loader_monitor

Overview:
Self-checking program loader and run monitor for the MIPS core's instruction-memory write port.
- Accepts instruction words over a valid/ready stream and writes them to consecutive word addresses through instwen/addwrite/instrdatain.
- Holds the core in reset while loading, then pulses reset and releases the core.
- Watches the data-memory write bus for a pass signature, with a cycle watchdog. Sits between the stimulus source and the top-level core.

Parameters:
DATA_W, 32, instruction/data word width
ADDR_W, 32, byte-address width
ADDR_STEP, 4, byte increment per loaded word
BASE_ADDR, 0, address of first loaded word
MAX_WORDS, 64, program capacity in words (≥2)
RST_CYCLES, 2, core reset pulse length after load (≥1)
TIMEOUT, 1024, max RUN cycles before fail (≥2)
PASS_ADDR, 84, signature store address
PASS_DATA, 7, expected signature value

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  begin load (IDLE) or restart (PASS/FAIL)
prog_valid  in  1  program word valid
prog_data  in  DATA_W  program word
prog_last  in  1  final word of program
prog_ready  out  1  loader accepting words
instwen  out  1  instruction-memory write enable
addwrite  out  ADDR_W  instruction-memory write address
instrdatain  out  DATA_W  instruction-memory write data
core_reset  out  1  reset to core
memWrite  in  1  core data-memory write strobe
Address  in  ADDR_W  core data-memory address
writeData  in  DATA_W  core data-memory write data
done  out  1  PASS or FAIL reached (level)
pass  out  1  signature matched (level)
fail_code  out  2  0 none, 1 data mismatch, 2 timeout
ovf  out  1  program truncated at MAX_WORDS
word_count  out  $clog2(MAX_WORDS+1)  words loaded
cycle_count  out  $clog2(TIMEOUT+1)  RUN cycles elapsed

Behaviour:
- States: IDLE, LOAD, RST_CORE, RUN, PASS, FAIL.
- Reset: state IDLE; core_reset=1; all other outputs 0; counters 0. Reset mid-operation aborts immediately, with no partial instwen on the following cycle.
- IDLE: core_reset=1. start=1 moves to LOAD.
- LOAD:
  - prog_ready=1, core_reset=1.
  - Handshake when prog_valid&prog_ready. Next cycle: instwen=1, addwrite=BASE_ADDR+word_count*ADDR_STEP (mod 2^ADDR_W), instrdatain=prog_data; word_count increments. Latency is exactly 1 cycle, registered outputs.
  - instwen=0 in any cycle without a preceding handshake. Gaps in valid are allowed.
  - Handshake with prog_last=1 ends the load and moves to RST_CORE.
  - The handshake that brings word_count to MAX_WORDS with prog_last=0 sets ovf=1 and moves to RST_CORE. prog_ready=0 from then on, so further words are not accepted.
- RST_CORE: core_reset=1 for RST_CYCLES cycles, then RUN. The final instwen pulse occurs in the first RST_CORE cycle.
- RUN:
  - core_reset=0. cycle_count increments each cycle, starting from 0.
  - memWrite=1 with Address==PASS_ADDR:
    - writeData==PASS_DATA → PASS.
    - otherwise → FAIL, fail_code=1.
  - Writes to other addresses are ignored.
  - cycle_count reaching TIMEOUT-1 with no hit → FAIL, fail_code=2.
  - If a hit and the timeout occur in the same cycle, the hit wins.
- PASS/FAIL:
  - core_reset=1 (core frozen); done=1; pass=1 only in PASS.
  - word_count, cycle_count, fail_code and ovf hold.
  - start=1 → LOAD; clears counters, ovf, fail_code, done and pass.
- start is ignored in LOAD, RST_CORE and RUN.

Decomposition:
- Package mips_tb_pkg: state enum, fail_code enum (FC_NONE, FC_MISMATCH, FC_TIMEOUT), default PASS_ADDR/PASS_DATA constants.
- Sub-module mips_run_watchdog: cycle counter plus signature comparator. Outputs hit_pass, hit_fail and timeout strobes.

Test Plan:
- Load 14 words, prog_last on the 14th; core stores 7 to address 84 → instwen pulses 14 times at addwrite 0,4,…,52 with data echoed; word_count=14; core_reset low 1+RST_CYCLES cycles after the last word; pass=1, fail_code=0.
- Same program, but the core stores 5 to address 84 → FAIL, fail_code=1, done=1, pass=0, core_reset=1.
- TIMEOUT=16, core never writes address 84 (writes to 80 ignored) → FAIL, fail_code=2 with cycle_count=15.
- MAX_WORDS=4, 6 words offered, no prog_last → exactly 4 writes (addresses 0..12); ovf=1; prog_ready=0 after the 4th handshake.
- prog_valid toggling every other cycle → instwen pulses only on cycles after handshakes; addresses contiguous.
- Reset asserted mid-LOAD after 3 words → next cycle IDLE, instwen=0, core_reset=1, word_count=0. Then start plus reload completes normally; start in PASS restarts LOAD with counters cleared.
